// File: rtl/pipe_forward_hazard_unit_pkg.sv
// Shared definitions for the forwarding / hazard unit.
//
// A tag describes one in-flight producer and is packed as
//   {valid, regwrite, memread, wreg[ADDR_W-1:0]}
// The three flag bits sit directly above the register address. Their
// positions are given as offsets from ADDR_W, because ADDR_W is a module
// parameter and is not known inside the package.
package pipe_forward_hazard_unit_pkg;

  // Number of flag bits stacked above wreg.
  localparam int TAG_FLAG_W   = 3;

  // Flag bit positions, each relative to ADDR_W.
  localparam int OFF_MEMREAD  = 0;
  localparam int OFF_REGWRITE = 1;
  localparam int OFF_VALID    = 2;

  // Every bit of a bubble tag takes this value, so a bubble never matches.
  localparam logic BUBBLE_FILL = 1'b0;

  // Width of a full tag: TAG_W = ADDR_W + 3.
  function automatic int tag_w(input int addr_w);
    return addr_w + TAG_FLAG_W;
  endfunction

endpackage

// File: rtl/pipe_forward_hazard_unit_fwd_operand_select.sv
// fwd_operand_select: forwarding mux for one ID-stage source operand.
//
// The unit picks the youngest in-flight producer of src_i, in the order
// EX, MEM, WB. If no producer matches, it falls back to the register file.
// It does not forward from an EX-stage load, because that data does not
// exist yet. In that case it raises load_hazard_o when the operand is
// actually used.
//
// Ports:
//   ex_tag_i / mem_tag_i / wb_tag_i  producer tags {valid,regwrite,memread,wreg}
//   src_i                            source register address
//   used_i                           the instruction reads this operand
//   rf_rdata_i                       register file read data
//   ex_result_i / mem_result_i / wb_result_i  producer data
//   operand_o                        selected operand
//   load_hazard_o                    operand depends on the load now in EX
module fwd_operand_select
  import pipe_forward_hazard_unit_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int ZERO_REG_EN = 1
) (
  input  logic [ADDR_W+TAG_FLAG_W-1:0] ex_tag_i,
  input  logic [ADDR_W+TAG_FLAG_W-1:0] mem_tag_i,
  input  logic [ADDR_W+TAG_FLAG_W-1:0] wb_tag_i,
  input  logic [ADDR_W-1:0]            src_i,
  input  logic                         used_i,
  input  logic [DATA_W-1:0]            rf_rdata_i,
  input  logic [DATA_W-1:0]            ex_result_i,
  input  logic [DATA_W-1:0]            mem_result_i,
  input  logic [DATA_W-1:0]            wb_result_i,
  output logic [DATA_W-1:0]            operand_o,
  output logic                         load_hazard_o
);

  logic src_ok;
  logic m_ex, m_mem, m_wb;
  logic ex_is_load;

  // With ZERO_REG_EN set, r0 is hardwired zero and never takes part in
  // matching.
  assign src_ok = (ZERO_REG_EN == 0) || (src_i != '0);

  assign m_ex  = ex_tag_i[ADDR_W+OFF_VALID]  & ex_tag_i[ADDR_W+OFF_REGWRITE]  &
                 (ex_tag_i[ADDR_W-1:0] == src_i)  & src_ok;
  assign m_mem = mem_tag_i[ADDR_W+OFF_VALID] & mem_tag_i[ADDR_W+OFF_REGWRITE] &
                 (mem_tag_i[ADDR_W-1:0] == src_i) & src_ok;
  assign m_wb  = wb_tag_i[ADDR_W+OFF_VALID]  & wb_tag_i[ADDR_W+OFF_REGWRITE]  &
                 (wb_tag_i[ADDR_W-1:0] == src_i)  & src_ok;

  assign ex_is_load = ex_tag_i[ADDR_W+OFF_MEMREAD];

  // The memread bits of MEM and WB do not affect forwarding: by MEM, load
  // data is already present on mem_result_i.
  logic unused_flags;
  assign unused_flags = mem_tag_i[ADDR_W+OFF_MEMREAD] ^ wb_tag_i[ADDR_W+OFF_MEMREAD];

  always_comb begin
    operand_o = rf_rdata_i;
    if (m_ex && !ex_is_load) begin
      operand_o = ex_result_i;
    end else if (m_mem) begin
      operand_o = mem_result_i;
    end else if (m_wb) begin
      operand_o = wb_result_i;
    end
  end

  assign load_hazard_o = used_i & m_ex & ex_is_load;

endmodule

// File: rtl/pipe_forward_hazard_unit.sv
// pipe_forward_hazard_unit: operand forwarding and load-use stall control
// between the register file read ports and the ID/EX pipeline register.
//
// The unit keeps its own EX/MEM/WB tag pipeline of destination registers.
// It forwards each ID source operand from the youngest matching producer.
// When a source depends on a load that is still in EX, it raises stall for
// exactly one cycle and drops a bubble into EX.
//
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   id_valid, id_rs, id_rt             ID instruction and its sources
//   id_rs_used, id_rt_used             which sources are actually read
//   id_wreg, id_regwrite, id_memread   ID destination / writes / is a load
//   flush                              kill the ID instruction this cycle
//   rf_rdata1, rf_rdata2               register file read data
//   ex_result, mem_result, wb_result   in-flight producer data
//   op1, op2                           forwarded operands
//   stall                              hold PC and IF/ID, bubble into EX
//   stall_count                        saturating count of stall cycles
//
// Handshake: there is no valid/ready pair. stall is a combinational request
// to hold the front end. The unit itself inserts the matching bubble on the
// same edge.
module pipe_forward_hazard_unit
  import pipe_forward_hazard_unit_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int CNT_W       = 16,
  parameter int ZERO_REG_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [ADDR_W-1:0] id_wreg,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              flush,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  input  logic [DATA_W-1:0] ex_result,
  input  logic [DATA_W-1:0] mem_result,
  input  logic [DATA_W-1:0] wb_result,
  output logic [DATA_W-1:0] op1,
  output logic [DATA_W-1:0] op2,
  output logic              stall,
  output logic [CNT_W-1:0]  stall_count
);

  localparam int TAG_W = tag_w(ADDR_W);
  localparam logic [TAG_W-1:0] BUBBLE = {TAG_W{BUBBLE_FILL}};

  logic [TAG_W-1:0] ex_q, ex_d;
  logic [TAG_W-1:0] mem_q;
  logic [TAG_W-1:0] wb_q;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             haz1, haz2;

  fwd_operand_select #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .ZERO_REG_EN (ZERO_REG_EN)
  ) u_sel_rs (
    .ex_tag_i      (ex_q),
    .mem_tag_i     (mem_q),
    .wb_tag_i      (wb_q),
    .src_i         (id_rs),
    .used_i        (id_rs_used),
    .rf_rdata_i    (rf_rdata1),
    .ex_result_i   (ex_result),
    .mem_result_i  (mem_result),
    .wb_result_i   (wb_result),
    .operand_o     (op1),
    .load_hazard_o (haz1)
  );

  fwd_operand_select #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .ZERO_REG_EN (ZERO_REG_EN)
  ) u_sel_rt (
    .ex_tag_i      (ex_q),
    .mem_tag_i     (mem_q),
    .wb_tag_i      (wb_q),
    .src_i         (id_rt),
    .used_i        (id_rt_used),
    .rf_rdata_i    (rf_rdata2),
    .ex_result_i   (ex_result),
    .mem_result_i  (mem_result),
    .wb_result_i   (wb_result),
    .operand_o     (op2),
    .load_hazard_o (haz2)
  );

  // A flushed instruction is dead, so it cannot cause a stall.
  assign stall = id_valid & ~flush & (haz1 | haz2);

  always_comb begin
    ex_d = {id_valid, id_regwrite, id_memread, id_wreg};
    if (stall || flush) begin
      ex_d = BUBBLE;
    end
  end

  // The counter saturates at all-ones and never wraps.
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q          <= BUBBLE;
      mem_q         <= BUBBLE;
      wb_q          <= BUBBLE;
      stall_count_q <= '0;
    end else begin
      ex_q          <= ex_d;
      mem_q         <= ex_q;
      wb_q          <= mem_q;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipe_forward_hazard_unit.sv
// Bench for pipe_forward_hazard_unit. A reference model holds the
// in-flight instructions as an age-ordered array (index 0 = youngest).
// Directed scenarios pin the model with literal values, then randomized
// traffic runs against the same model.
module tb_pipe_forward_hazard_unit;

  localparam int DATA_W      = 32;
  localparam int ADDR_W      = 5;
  localparam int CNT_W       = 2;
  localparam int ZERO_REG_EN = 1;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              id_valid, id_rs_used, id_rt_used, id_regwrite, id_memread, flush;
  logic [ADDR_W-1:0] id_rs, id_rt, id_wreg;
  logic [DATA_W-1:0] rf_rdata1, rf_rdata2, ex_result, mem_result, wb_result;
  logic [DATA_W-1:0] op1, op2;
  logic              stall;
  logic [CNT_W-1:0]  stall_count;

  pipe_forward_hazard_unit #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W), .ZERO_REG_EN(ZERO_REG_EN)
  ) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_wreg(id_wreg), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .flush(flush),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .ex_result(ex_result), .mem_result(mem_result), .wb_result(wb_result),
    .op1(op1), .op2(op2), .stall(stall), .stall_count(stall_count)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act,
                     input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          v;
    bit          rw;
    bit          ld;
    int unsigned dst;
  } instr_t;

  instr_t      pipe[3];  // 0 = EX, 1 = MEM, 2 = WB
  int unsigned m_cnt;
  bit          ready = 1'b0;

  function automatic bit writes(input int s, input int unsigned r);
    if (ZERO_REG_EN != 0 && r == 0) return 1'b0;
    return pipe[s].v && pipe[s].rw && pipe[s].dst == r;
  endfunction

  // Youngest producer wins. The data of a load still in EX does not exist
  // yet, so the search skips it and continues to older stages.
  function automatic logic [DATA_W-1:0] m_fwd(input int unsigned r,
                                              input logic [DATA_W-1:0] rf);
    logic [DATA_W-1:0] src[3];
    src[0] = ex_result; src[1] = mem_result; src[2] = wb_result;
    for (int s = 0; s < 3; s++) begin
      if (writes(s, r) && !(s == 0 && pipe[0].ld)) return src[s];
    end
    return rf;
  endfunction

  function automatic bit m_stall();
    if (!id_valid || flush || !pipe[0].ld) return 1'b0;
    return (id_rs_used && writes(0, id_rs)) || (id_rt_used && writes(0, id_rt));
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < 3; s++) pipe[s] = '{default: 0};
      m_cnt = 0;
      ready = 1'b1;
    end else begin
      bit s_now;
      s_now = m_stall();
      if (s_now && m_cnt < CNT_MAX) m_cnt++;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      if (s_now || flush) pipe[0] = '{default: 0};
      else pipe[0] = '{v: id_valid, rw: id_regwrite, ld: id_memread, dst: id_wreg};
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (ready) begin
      chk("op1",         op1,                    m_fwd(id_rs, rf_rdata1));
      chk("op2",         op2,                    m_fwd(id_rt, rf_rdata2));
      chk("stall",       DATA_W'(stall),         DATA_W'(m_stall()));
      chk("stall_count", DATA_W'(stall_count),   DATA_W'(m_cnt));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_rs = '0; id_rt = '0; id_rs_used = 0; id_rt_used = 0;
    id_wreg = '0; id_regwrite = 0; id_memread = 0; flush = 0;
  endtask

  task automatic issue_write(input int unsigned r, input bit is_load);
    idle();
    id_valid = 1; id_wreg = ADDR_W'(r); id_regwrite = 1; id_memread = is_load;
  endtask

  task automatic read_rs(input int unsigned r);
    idle();
    id_valid = 1; id_rs = ADDR_W'(r); id_rs_used = 1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick();
    reset = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1;
    idle();
    rf_rdata1 = 32'h1111_0001; rf_rdata2 = 32'h2222_0002;
    ex_result = 32'h0; mem_result = 32'h0; wb_result = 32'h0;
    tick();
    reset = 0;

    // After reset: no stall, operands straight from the register file.
    read_rs(7);
    #3;
    chk("rst_op1", op1, 32'h1111_0001);
    chk("rst_stall", DATA_W'(stall), 0);
    chk("rst_cnt", DATA_W'(stall_count), 0);

    // ALU RAW at distance 1.
    issue_write(8, 0);
    tick();
    read_rs(8); ex_result = 32'h0000_00AA;
    #3;
    chk("raw_op1", op1, 32'h0000_00AA);
    chk("raw_stall", DATA_W'(stall), 0);

    // Priority: EX, MEM and WB all write r9.
    do_reset();
    issue_write(9, 0); tick();
    issue_write(9, 0); tick();
    issue_write(9, 0); tick();
    idle(); id_valid = 1; id_rt = 9; id_rt_used = 1;
    ex_result = 32'h1; mem_result = 32'h2; wb_result = 32'h3;
    #3;
    chk("prio_ex", op2, 32'h1);
    tick();  // a non-writer enters EX
    #3;
    chk("prio_mem", op2, 32'h2);
    tick();
    #3;
    chk("prio_wb", op2, 32'h3);

    // Load-use: one stall cycle, then forwarded from MEM.
    do_reset();
    issue_write(5, 1); tick();
    read_rs(5);
    #3;
    chk("lu_stall", DATA_W'(stall), 1);
    tick();
    mem_result = 32'hDEAD_BEEF;
    #3;
    chk("lu_op1", op1, 32'hDEAD_BEEF);
    chk("lu_stall_clr", DATA_W'(stall), 0);
    chk("lu_cnt", DATA_W'(stall_count), 1);

    // Register 0 is never matched, even for a load.
    do_reset();
    issue_write(0, 1); tick();
    read_rs(0); rf_rdata1 = 32'h0; ex_result = 32'h55;
    #3;
    chk("r0_op1", op1, 32'h0);
    chk("r0_stall", DATA_W'(stall), 0);

    // Flush in the hazard cycle suppresses the stall.
    do_reset();
    issue_write(5, 1); tick();
    read_rs(5); flush = 1;
    #3;
    chk("fl_stall", DATA_W'(stall), 0);
    tick();
    read_rs(5); mem_result = 32'h0BAD_F00D;
    #3;
    chk("fl_cnt", DATA_W'(stall_count), 0);
    chk("fl_bubble", DATA_W'(stall), 0);
    chk("fl_op1", op1, 32'h0BAD_F00D);

    // Saturation: four load-use stalls with a 2-bit counter.
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      issue_write(k, 1); tick();
      read_rs(k);
      #3;
      chk("sat_stall", DATA_W'(stall), 1);
      tick();
    end
    idle();
    #3;
    chk("sat_cnt", DATA_W'(stall_count), 3);
    do_reset();
    read_rs(1); rf_rdata1 = 32'h1234_5678;
    #3;
    chk("sat_rst_cnt", DATA_W'(stall_count), 0);
    chk("sat_rst_op1", op1, 32'h1234_5678);

    // Reset asserted mid-stall.
    issue_write(3, 1); tick();
    read_rs(3);
    #3;
    chk("mid_stall", DATA_W'(stall), 1);
    reset = 1;
    tick();
    reset = 0;
    #3;
    chk("mid_rst_stall", DATA_W'(stall), 0);

    // Randomized traffic over a small register range to force collisions.
    for (int i = 0; i < 2000; i++) begin
      tick();
      reset       = ($urandom_range(0, 99) < 2);
      id_valid    = ($urandom_range(0, 9) < 8);
      id_rs       = ADDR_W'($urandom_range(0, 3));
      id_rt       = ADDR_W'($urandom_range(0, 3));
      id_rs_used  = $urandom_range(0, 1);
      id_rt_used  = $urandom_range(0, 1);
      id_wreg     = ADDR_W'($urandom_range(0, 3));
      id_regwrite = ($urandom_range(0, 9) < 7);
      id_memread  = ($urandom_range(0, 9) < 4);
      flush       = ($urandom_range(0, 9) == 0);
      rf_rdata1   = $urandom;
      rf_rdata2   = $urandom;
      ex_result   = $urandom;
      mem_result  = $urandom;
      wb_result   = $urandom;
    end
    tick();
    reset = 0;
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_forward_hazard_unit.md
Name: pipe_forward_hazard_unit

Overview:
Parametrised successor to the WB-stage forwarding logic. It resolves data hazards for the two ID-stage source operands against every in-flight producer: EX, MEM and WB, in that priority order. It keeps its own registered tag pipeline of destination registers. It detects load-use hazards and issues a one-cycle stall with bubble insertion. It also keeps a saturating stall-cycle counter. It sits between the register file read ports and the ID/EX pipeline register.

Parameters:
DATA_W, 32, operand/result width
ADDR_W, 5, register address width
CNT_W, 16, stall counter width
ZERO_REG_EN, 1, when 1 register address 0 is hardwired zero and is never matched or forwarded

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
id_valid  in  1  ID stage holds a real instruction
id_rs  in  ADDR_W  ID source register 1
id_rt  in  ADDR_W  ID source register 2
id_rs_used  in  1  instruction reads rs
id_rt_used  in  1  instruction reads rt
id_wreg  in  ADDR_W  ID destination register
id_regwrite  in  1  ID instruction writes the register file
id_memread  in  1  ID instruction is a load
flush  in  1  kill the ID instruction (taken branch/jump)
rf_rdata1  in  DATA_W  register file read data for rs
rf_rdata2  in  DATA_W  register file read data for rt
ex_result  in  DATA_W  ALU result of the instruction in EX
mem_result  in  DATA_W  result in MEM (load data or ALU value)
wb_result  in  DATA_W  write-back data
op1  out  DATA_W  forwarded rs operand
op2  out  DATA_W  forwarded rt operand
stall  out  1  hold PC and IF/ID; insert bubble
stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high on port reset, sampled on the rising edge.
- Tag pipeline: three registered tags, EX, MEM and WB, each {valid, regwrite, memread, wreg}.
- On reset, all tags are cleared to 0 and stall_count is cleared to 0. After reset, stall=0 and op1/op2 equal rf_rdata1/rf_rdata2.
- Each rising edge without reset: WB<=MEM, MEM<=EX.
- EX load on each edge:
  - If stall=1 or flush=1: EX<=bubble (all fields 0).
  - Otherwise: EX<={id_valid, id_regwrite, id_memread, id_wreg}.
- Match(stage, r) is true when all of the following hold:
  - stage.valid and stage.regwrite are both 1;
  - stage.wreg==r;
  - if ZERO_REG_EN=1, r!=0.
- Operand selection (combinational, zero-cycle latency), per operand independently:
  - Match(EX) and EX.memread=0 -> ex_result;
  - else Match(MEM) -> mem_result;
  - else Match(WB) -> wb_result;
  - else the register file value.
  - A younger stage always wins over an older one.
- Load-use hazard: hazard = id_valid & !flush & ((id_rs_used & Match(EX,id_rs)) | (id_rt_used & Match(EX,id_rt))) & EX.memread.
  - stall=hazard, combinational.
  - On the next edge the bubble enters EX and the load moves to MEM. The hazard then clears and MEM forwards the loaded value.
  - Exactly one stall cycle per load-use pair.
- Operands are never forwarded from an EX-stage load. While stalled, op1/op2 still reflect the best available source, but downstream discards them.
- flush=1 suppresses stall in the same cycle and inserts a bubble into EX.
- stall_count increments by 1 on each edge where stall=1. It saturates at all-ones and never wraps.
- Reset asserted mid-stall: tags clear on that edge, and stall deasserts in the following cycle.

Decomposition:
- Shared header holds:
  - tag field width constants (TAG_W = ADDR_W+3);
  - field offset localparams;
  - the bubble constant.
- Sub-module fwd_operand_select: one per operand, instantiated twice.
  - Inputs: the three tags, the source register, its used flag, and the four data sources.
  - Outputs: the selected operand and a per-operand load-hazard flag.

Test Plan:
- ALU RAW, distance 1: EX tag {wreg=8, regwrite=1}, ID rs=8, ex_result=0x0000_00AA -> op1=0xAA, stall=0.
- Priority: EX, MEM and WB all write r9 with values 0x1, 0x2, 0x3 -> op2=0x1. Clear EX -> op2=0x2. Clear MEM -> op2=0x3.
- Load-use: load to r5 in EX, ID rs=5 used:
  - stall=1 for exactly one cycle and EX becomes a bubble;
  - next cycle mem_result=0xDEAD_BEEF gives op1=0xDEADBEEF, stall=0;
  - stall_count=1.
- Register 0: EX writes r0 with ex_result=0x55 and ID rs=0 -> op1=rf_rdata1 (0), no stall even if the EX instruction is a load.
- Flush with load-use pending: flush=1 in the hazard cycle -> stall=0, EX bubble, stall_count unchanged.
- Saturation and reset: CNT_W=2, four consecutive load-use stalls -> stall_count=3. Assert reset -> stall_count=0, all tags cleared, op1=rf_rdata1.
